// File: rtl/dm_dly_pkg.sv
// Shared types and constants for the IOD delay-line tap controller.
package dm_dly_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } dly_state_t;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    // Wide enough for the largest settle gap (15 cycles).
    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/dm_dly_gap_cnt.sv
// Down-counter timing the settle gap after each delay-line MOVE pulse.
module dm_dly_gap_cnt
    import dm_dly_pkg::*;
#(
    parameter int CNT_W = GAP_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // High during the final gap cycle so the FSM leaves GAP on the next edge.
    assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/dm_delay_line_ctrl.sv
// Steps an IOD delay line to a requested tap with MOVE/LOAD pulses and a settle gap.
// Optional build macro DM_DLY_CTRL_AUTO_RELOAD_EN: reload the line after an out-of-range abort.
module dm_delay_line_ctrl
    import dm_dly_pkg::*;
#(
    parameter int TAP_W     = 8,
    parameter int RESET_TAP = 1,
    parameter int MAX_TAP   = 255,
    parameter int MOVE_GAP  = 3
) (
    input  logic             FAB_CLK,
    input  logic             TX_SYNC_RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [TAP_W-1:0] REQ_TAP,
    input  logic             REQ_LOAD,
    output logic             DONE,
    output logic             ERR,
    output logic [TAP_W-1:0] CUR_TAP,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_LOAD,
    input  logic             DELAY_LINE_OUT_OF_RANGE
);

    localparam logic [TAP_W:0]     MAX_TAP_X = (TAP_W+1)'(MAX_TAP);
    localparam logic [TAP_W-1:0]   RESET_V   = TAP_W'(RESET_TAP);
    localparam logic [GAP_CNT_W-1:0] GAP_V   = GAP_CNT_W'(MOVE_GAP);

    dly_state_t       state;
    logic [TAP_W-1:0] target;
    logic             abort_pend;
    logic             gap_load;
    logic             gap_expire;
    logic [TAP_W-1:0] step_tap;

    assign gap_load = (state == ST_PULSE);
    assign step_tap = (DELAY_LINE_DIRECTION == DIR_INC) ? CUR_TAP + 1'b1 : CUR_TAP - 1'b1;

    dm_dly_gap_cnt #(
        .CNT_W (GAP_CNT_W)
    ) u_gap_cnt (
        .clk      (FAB_CLK),
        .rst      (TX_SYNC_RST),
        .load     (gap_load),
        .load_val (GAP_V),
        .expire   (gap_expire)
    );

    always_ff @(posedge FAB_CLK) begin
        if (TX_SYNC_RST) begin
            state                <= ST_IDLE;
            CUR_TAP              <= RESET_V;
            ERR                  <= 1'b0;
            DONE                 <= 1'b0;
            DELAY_LINE_MOVE      <= 1'b0;
            DELAY_LINE_LOAD      <= 1'b0;
            DELAY_LINE_DIRECTION <= DIR_DEC;
            REQ_READY            <= 1'b1;
            abort_pend           <= 1'b0;
        end else begin
            DONE            <= 1'b0;
            DELAY_LINE_MOVE <= 1'b0;
            DELAY_LINE_LOAD <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        REQ_READY  <= 1'b0;
                        ERR        <= 1'b0;
                        target     <= REQ_TAP;
                        abort_pend <= 1'b0;
                        // Range check wins over LOAD: an illegal target touches nothing.
                        if ({1'b0, REQ_TAP} > MAX_TAP_X) begin
                            ERR   <= 1'b1;
                            DONE  <= 1'b1;
                            state <= ST_DONE;
                        end else if (REQ_LOAD) begin
                            DELAY_LINE_LOAD <= 1'b1;
                            CUR_TAP         <= RESET_V;
                            state           <= ST_LOAD;
                        end else if (REQ_TAP == CUR_TAP) begin
                            DONE  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            DELAY_LINE_DIRECTION <= (REQ_TAP > CUR_TAP) ? DIR_INC : DIR_DEC;
                            state                <= ST_SETUP;
                        end
                    end
                end
                ST_LOAD: begin
                    if (abort_pend || (target == CUR_TAP)) begin
                        DONE  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        DELAY_LINE_DIRECTION <= (target > CUR_TAP) ? DIR_INC : DIR_DEC;
                        state                <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    DELAY_LINE_MOVE <= 1'b1;
                    state           <= ST_PULSE;
                end
                ST_PULSE: begin
                    state <= ST_GAP;
                end
                ST_GAP: begin
                    if (DELAY_LINE_OUT_OF_RANGE) begin
                        // The IOD refused the step, so the tracked tap stays put.
                        ERR <= 1'b1;
`ifdef DM_DLY_CTRL_AUTO_RELOAD_EN
                        abort_pend      <= 1'b1;
                        DELAY_LINE_LOAD <= 1'b1;
                        CUR_TAP         <= RESET_V;
                        state           <= ST_LOAD;
`else
                        DONE  <= 1'b1;
                        state <= ST_DONE;
`endif
                    end else if (gap_expire) begin
                        CUR_TAP <= step_tap;
                        if (step_tap == target) begin
                            DONE  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            DELAY_LINE_DIRECTION <= (target > step_tap) ? DIR_INC : DIR_DEC;
                            state                <= ST_SETUP;
                        end
                    end
                end
                ST_DONE: begin
                    REQ_READY <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    REQ_READY <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_delay_line_ctrl.sv
// Table-driven self-checking bench for dm_delay_line_ctrl with a result scoreboard.
module tb_dm_delay_line_ctrl;

    localparam int TAP_W     = 9;
    localparam int RESET_TAP = 1;
    localparam int MAX_TAP   = 255;
    localparam int MOVE_GAP  = 3;
    localparam int STEP_LAT  = 2 + MOVE_GAP;
`ifdef DM_DLY_CTRL_AUTO_RELOAD_EN
    localparam int RL = 1;
`else
    localparam int RL = 0;
`endif

    logic             FAB_CLK;
    logic             TX_SYNC_RST;
    logic             REQ_VALID;
    logic             REQ_READY;
    logic [TAP_W-1:0] REQ_TAP;
    logic             REQ_LOAD;
    logic             DONE;
    logic             ERR;
    logic [TAP_W-1:0] CUR_TAP;
    logic             DELAY_LINE_MOVE;
    logic             DELAY_LINE_DIRECTION;
    logic             DELAY_LINE_LOAD;
    logic             DELAY_LINE_OUT_OF_RANGE;

    dm_delay_line_ctrl #(
        .TAP_W     (TAP_W),
        .RESET_TAP (RESET_TAP),
        .MAX_TAP   (MAX_TAP),
        .MOVE_GAP  (MOVE_GAP)
    ) dut (
        .FAB_CLK                 (FAB_CLK),
        .TX_SYNC_RST             (TX_SYNC_RST),
        .REQ_VALID               (REQ_VALID),
        .REQ_READY               (REQ_READY),
        .REQ_TAP                 (REQ_TAP),
        .REQ_LOAD                (REQ_LOAD),
        .DONE                    (DONE),
        .ERR                     (ERR),
        .CUR_TAP                 (CUR_TAP),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE)
    );

    initial begin
        FAB_CLK = 1'b0;
        forever #5 FAB_CLK = ~FAB_CLK;
    end

    // oor_gap: force OUT_OF_RANGE in the gap following that MOVE (0 = never).
    typedef struct {
        int tap;
        bit load;
        int oor_gap;
        int e_cur;
        bit e_err;
        int e_moves;
        int e_loads;
        int e_done;
        bit e_dir;
    } vec_t;

    vec_t tbl [14];
    vec_t sb_q [$];
    int   n_vec;
    int   n_err;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        vec_t e;
        int   cyc, moves, loads, done_cyc, last_move, first_move, n;
        bit   oor_done, got_done;
        string tag;
        tag = $sformatf("v%0d", idx);
        n = 0;
        while (!REQ_READY && n < 50) begin
            @(negedge FAB_CLK);
            n++;
        end
        chk({tag, " ready_before"}, int'(REQ_READY), 1);
        REQ_TAP   = v.tap[TAP_W-1:0];
        REQ_LOAD  = v.load;
        REQ_VALID = 1'b1;
        sb_q.push_back(v);
        @(negedge FAB_CLK);
        REQ_VALID = 1'b0;
        REQ_TAP   = TAP_W'($urandom);
        REQ_LOAD  = 1'($urandom_range(0, 1));
        cyc = 1; moves = 0; loads = 0; done_cyc = -1; last_move = -100;
        oor_done = 0; got_done = 0;
        first_move = 2 + (v.load ? 1 : 0);
        chk({tag, " ready_busy"}, int'(REQ_READY), 0);
        while (cyc < 3000 && !got_done) begin
            DELAY_LINE_OUT_OF_RANGE = 1'b0;
            if (cyc == 1 && !v.load && v.e_moves > 0)
                chk({tag, " dir_cycle1"}, int'(DELAY_LINE_DIRECTION), int'(v.e_dir));
            if (DELAY_LINE_MOVE) begin
                chk({tag, " move_cycle"}, cyc, first_move + moves * STEP_LAT);
                chk({tag, " move_dir"}, int'(DELAY_LINE_DIRECTION), int'(v.e_dir));
                last_move = cyc;
                moves++;
            end
            if (DELAY_LINE_LOAD) loads++;
            if (v.oor_gap != 0 && moves == v.oor_gap && cyc == last_move + 1 && !oor_done) begin
                DELAY_LINE_OUT_OF_RANGE = 1'b1;
                oor_done = 1;
            end
            if (DONE) begin
                done_cyc = cyc;
                got_done = 1;
            end else begin
                @(negedge FAB_CLK);
                cyc++;
            end
        end
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        chk({tag, " done_seen"}, int'(got_done), 1);
        e = sb_q.pop_front();
        chk({tag, " done_cycle"}, done_cyc, e.e_done);
        chk({tag, " cur_tap"}, int'(CUR_TAP), e.e_cur);
        chk({tag, " err"}, int'(ERR), int'(e.e_err));
        chk({tag, " moves"}, moves, e.e_moves);
        chk({tag, " loads"}, loads, e.e_loads);
        @(negedge FAB_CLK);
        chk({tag, " done_one_cycle"}, int'(DONE), 0);
        chk({tag, " ready_after"}, int'(REQ_READY), 1);
        chk({tag, " err_sticky"}, int'(ERR), int'(e.e_err));
    endtask

    initial begin
        vec_t v;
        int   n;
        bit   stray;
        n_vec = 0;
        n_err = 0;
        //            tap  ld oor cur        err moves      loads   done          dir
        tbl[0]  = '{2,   0, 0, 2,          0,  1,         0,      6,            1};
        tbl[1]  = '{5,   0, 0, 5,          0,  3,         0,      16,           1};
        tbl[2]  = '{2,   0, 0, 2,          0,  3,         0,      16,           0};
        tbl[3]  = '{1,   1, 0, 1,          0,  0,         1,      2,            0};
        tbl[4]  = '{256, 0, 0, 1,          1,  0,         0,      1,            0};
        tbl[5]  = '{1,   0, 0, 1,          0,  0,         0,      1,            0};
        tbl[6]  = '{4,   1, 0, 4,          0,  3,         1,      17,           1};
        tbl[7]  = '{7,   0, 2, RL ? 1 : 5, 1,  2,         RL,     9 + RL,       1};
        tbl[8]  = '{0,   0, 0, 0,          0,  RL ? 1 : 5, 0,     RL ? 6 : 26,  0};
        tbl[9]  = '{0,   0, 0, 0,          0,  0,         0,      1,            0};
        tbl[10] = '{3,   1, 1, 1,          1,  1,         1 + RL, 5 + RL,       1};
        tbl[11] = '{255, 0, 0, 255,        0,  254,       0,      1271,         1};
        tbl[12] = '{256, 1, 0, 255,        1,  0,         0,      1,            0};
        tbl[13] = '{511, 0, 0, 255,        1,  0,         0,      1,            0};

        TX_SYNC_RST = 1'b1;
        REQ_VALID = 1'b0;
        REQ_TAP = '0;
        REQ_LOAD = 1'b0;
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        TX_SYNC_RST = 1'b0;
        @(negedge FAB_CLK);
        chk("rst ready", int'(REQ_READY), 1);
        chk("rst cur_tap", int'(CUR_TAP), RESET_TAP);
        chk("rst err", int'(ERR), 0);
        chk("rst done", int'(DONE), 0);
        chk("rst move", int'(DELAY_LINE_MOVE), 0);
        chk("rst load", int'(DELAY_LINE_LOAD), 0);
        chk("rst dir", int'(DELAY_LINE_DIRECTION), 0);

        for (int i = 0; i < 14; i++) run_vec(i, tbl[i]);

        // Reset while the MOVE pulse is out: abort with no DONE and tap back at reset value.
        REQ_TAP = TAP_W'(5);
        REQ_LOAD = 1'b0;
        REQ_VALID = 1'b1;
        @(negedge FAB_CLK);
        REQ_VALID = 1'b0;
        n = 0;
        while (!DELAY_LINE_MOVE && n < 20) begin
            @(negedge FAB_CLK);
            n++;
        end
        chk("midrst move_seen", int'(DELAY_LINE_MOVE), 1);
        TX_SYNC_RST = 1'b1;
        @(negedge FAB_CLK);
        chk("midrst move_low", int'(DELAY_LINE_MOVE), 0);
        TX_SYNC_RST = 1'b0;
        @(negedge FAB_CLK);
        chk("midrst cur_tap", int'(CUR_TAP), RESET_TAP);
        chk("midrst ready", int'(REQ_READY), 1);
        chk("midrst err", int'(ERR), 0);
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            if (DONE || DELAY_LINE_MOVE || DELAY_LINE_LOAD) stray = 1;
            @(negedge FAB_CLK);
        end
        chk("midrst no_pulses", int'(stray), 0);

        v = '{3, 0, 0, 3, 0, 2, 0, 11, 1};
        run_vec(99, v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule
